// File: rtl/aes_key_sched_iter.sv
// ---------------------------------------------------------------------------
// aes_key_sched_iter
//
// Iterative AES key-schedule engine for AES-128/192/256. A single shared
// SubWord stage (four S-boxes) produces one 32-bit schedule word per clock.
// Every word is kept in an internal buffer, and round keys are read back
// combinationally by index.
//
// Parameters
//   MAX_NK        largest key length in words (4, 6 or 8); buffer holds
//                 4*(MAX_NK+7) words
//   ZERO_INVALID  1: rk_out reads 0 while valid=0 or rk_idx > Nr
//
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous active-high reset
//   start    in   1    expand request, accepted only while busy=0
//   key_len  in   2    00=128, 01=192, 10=256, 11=illegal
//   key      in   256  cipher key, MSB aligned
//   busy     out  1    expansion in progress
//   done     out  1    one-cycle pulse when the last word is written
//   err      out  1    one-cycle pulse when start is rejected for key_len
//   valid    out  1    buffer holds a complete schedule for the last key
//   rk_idx   in   4    round-key index 0..Nr
//   rk_out   out  128  {w[4k], w[4k+1], w[4k+2], w[4k+3]}, k = rk_idx
//
// Request handshake: start is a one-cycle request. It is taken on a rising
// edge only when busy=0, and it then sets busy=1 for the whole expansion.
// A start seen while busy=1 is dropped silently. A start with an
// unsupported key_len leaves all state untouched and raises err for the
// following cycle.
// ---------------------------------------------------------------------------
module aes_key_sched_iter #(
    parameter int MAX_NK       = 8,
    parameter int ZERO_INVALID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers. The S-box is built from its definition, the
    // multiplicative inverse followed by the affine transform, rather than
    // from a 256-entry table.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // The inverse is a^254 = a^2 * a^4 * ... * a^128. This maps 0 to 0,
    // which is exactly what the S-box requires.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic           r_done;
    logic           r_err;
    logic           r_valid;
    logic [7:0]     r_rcon;
    logic [AW-1:0]  r_i;        // index of the word written this cycle
    logic [2:0]     r_j;        // position within the current Nk-word group
    logic [2:0]     r_jmax;     // Nk-1
    logic           r_nk8;      // AES-256: extra SubWord at j==4
    logic [AW-1:0]  r_nk;
    logic [3:0]     r_nr;
    logic [AW-1:0]  r_last;     // 4*(Nr+1)-1
    logic [31:0]    r_buf [DEPTH];

    // ------------------------------------------------------------------
    // key_len decode
    // ------------------------------------------------------------------
    logic [3:0] w_nk_in;
    logic [3:0] w_nr_in;
    logic [5:0] w_last_in;
    logic       w_legal;

    always_comb begin
        w_nk_in   = 4'd0;
        w_nr_in   = 4'd0;
        w_last_in = 6'd0;
        case (key_len)
            2'b00: begin w_nk_in = 4'd4; w_nr_in = 4'd10; w_last_in = 6'd43; end
            2'b01: begin w_nk_in = 4'd6; w_nr_in = 4'd12; w_last_in = 6'd51; end
            2'b10: begin w_nk_in = 4'd8; w_nr_in = 4'd14; w_last_in = 6'd59; end
            default: ;
        endcase
        w_legal = (key_len != 2'b11) && (32'(w_nk_in) <= MAX_NK);
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_reject;
    logic w_last_word;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_last_word  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_legal) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_EXPAND;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                if (r_i == r_last) begin
                    w_last_word  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Word generator: w[i] = w[i-Nk] ^ temp(w[i-1])
    // ------------------------------------------------------------------
    logic [AW-1:0] w_prev_idx;
    logic [AW-1:0] w_back_idx;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_sub_in;
    logic [31:0]   w_sub_out;
    logic [31:0]   w_temp;
    logic [31:0]   w_new_word;

    always_comb begin
        w_prev_idx = r_i - AW'(1);
        w_back_idx = r_i - r_nk;
        w_prev     = r_buf[w_prev_idx];
        w_back     = r_buf[w_back_idx];
        // RotWord is applied only at the start of a group; the same four
        // S-boxes then serve the AES-256 mid-group SubWord.
        w_sub_in   = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub_out  = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                      sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};
        if (r_j == 3'd0)
            w_temp = w_sub_out ^ {r_rcon, 24'h000000};
        else if (r_nk8 && (r_j == 3'd4))
            w_temp = w_sub_out;
        else
            w_temp = w_prev;
        w_new_word = w_back ^ w_temp;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_rcon  <= 8'h01;
            r_i     <= '0;
            r_j     <= '0;
            r_jmax  <= '0;
            r_nk8   <= 1'b0;
            r_nk    <= '0;
            r_nr    <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last_word;
            r_err   <= w_reject;
            if (w_accept) begin
                r_valid <= 1'b0;
                r_rcon  <= 8'h01;
                r_i     <= AW'(w_nk_in);
                r_j     <= 3'd0;
                r_jmax  <= 3'(w_nk_in - 4'd1);
                r_nk8   <= (key_len == 2'b10);
                r_nk    <= AW'(w_nk_in);
                r_nr    <= w_nr_in;
                r_last  <= AW'(w_last_in);
            end else if (r_state == ST_EXPAND) begin
                r_i <= r_i + AW'(1);
                r_j <= (r_j == r_jmax) ? 3'd0 : r_j + 3'd1;
                if (r_j == 3'd0) r_rcon <= xtime(r_rcon);
                if (w_last_word) r_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word buffer (no reset; contents only matter once valid is set)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept) begin
                for (int k = 0; k < MAX_NK; k++) begin
                    if (k < int'(w_nk_in)) r_buf[AW'(k)] <= key[255-32*k -: 32];
                end
            end else if (r_state == ST_EXPAND) begin
                r_buf[r_i] <= w_new_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    logic [5:0] w_rd_base;
    logic [5:0] w_rd_idx;
    logic       w_rd_zero;

    always_comb begin
        rk_out    = '0;
        w_rd_idx  = '0;
        w_rd_base = {rk_idx, 2'b00};
        w_rd_zero = (ZERO_INVALID != 0) && (!r_valid || (rk_idx > r_nr));
        if (!w_rd_zero) begin
            for (int q = 0; q < 4; q++) begin
                w_rd_idx = w_rd_base + 6'(q);
                // Indices beyond the buffer read as 0 rather than wrapping.
                if (32'(w_rd_idx) < DEPTH) rk_out[127-32*q -: 32] = r_buf[AW'(w_rd_idx)];
            end
        end
    end

    assign busy  = (r_state == ST_EXPAND);
    assign done  = r_done;
    assign err   = r_err;
    assign valid = r_valid;

endmodule
